// File: rtl/expr_pkg.sv
// Shared definitions for the ASCII expression parser.
// Holds the ASCII character codes that the parser recognises, the parser
// FSM state encoding, and the character-class helper functions.
// The operator codes are also the defaults for the downstream comparator.
package expr_pkg;

    localparam logic [7:0] CH_DIGIT_LO = 8'h30;
    localparam logic [7:0] CH_DIGIT_HI = 8'h39;
    localparam logic [7:0] CH_PLUS     = 8'h2B;
    localparam logic [7:0] CH_MINUS    = 8'h2D;
    localparam logic [7:0] CH_STAR     = 8'h2A;
    localparam logic [7:0] CH_SLASH    = 8'h2F;
    localparam logic [7:0] CH_SPACE    = 8'h20;
    localparam logic [7:0] CH_EQ       = 8'h3D;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_LF       = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_A    = 3'd1,
        S_B0   = 3'd2,
        S_B    = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_DIGIT_LO) && (c <= CH_DIGIT_HI);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == CH_PLUS) || (c == CH_MINUS) || (c == CH_STAR) || (c == CH_SLASH);
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == CH_EQ) || (c == CH_CR) || (c == CH_LF);
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal accumulate step: acc_next = acc*10 + digit.
// Ports:
//   acc      - current accumulator value (WIDTH bits)
//   digit    - decimal digit 0..9
//   acc_next - low WIDTH bits of the result
//   overflow - result does not fit in WIDTH bits
module dec_accum #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] acc_next,
    output logic             overflow
);

    // Four extra bits hold (2^WIDTH-1)*10+9 without wrapping.
    localparam logic [WIDTH+3:0] TEN = (WIDTH+4)'(10);

    logic [WIDTH+3:0] wide;

    always_comb begin
        wide     = ({4'd0, acc} * TEN) + {{WIDTH{1'b0}}, digit};
        acc_next = wide[WIDTH-1:0];
        overflow = |wide[WIDTH+3:WIDTH];
    end

endmodule

// File: rtl/ascii_expr_parser.sv
// ASCII infix expression parser: "<A><op><B><term>", e.g. "12+34=".
// Ports:
//   i_clk, reset_n          - clock, async active-low reset
//   i_valid, i_data         - byte stream from the UART receiver
//   o_op_ready, o_op        - operator strobe / held operator character
//   o_operand_a/b           - operands of the last complete expression
//   o_expr_valid            - strobe: operands updated for a complete expression
//   o_error                 - strobe: first syntax/overflow fault of an expression
//   o_busy                  - an expression is partially received
//
// state  | meaning
// S_IDLE | waiting for the first digit of A (terminators ignored)
// S_A    | accumulating A, waiting for operator
// S_B0   | operator seen, waiting for first digit of B
// S_B    | accumulating B, waiting for terminator
// S_ERR  | faulted, discarding bytes until a terminator
module ascii_expr_parser
    import expr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic [7:0]       i_data,
    output logic             o_op_ready,
    output logic [7:0]       o_op,
    output logic [WIDTH-1:0] o_operand_a,
    output logic [WIDTH-1:0] o_operand_b,
    output logic             o_expr_valid,
    output logic             o_error,
    output logic             o_busy
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   a_stage_q, a_stage_d;
    logic [7:0]         op_q, op_d;
    logic [WIDTH-1:0]   operand_a_q, operand_a_d;
    logic [WIDTH-1:0]   operand_b_q, operand_b_d;
    logic               op_ready_q, op_ready_d;
    logic               expr_valid_q, expr_valid_d;
    logic               error_q, error_d;

    logic [WIDTH-1:0]   acc_in;
    logic [WIDTH-1:0]   acc_sum;
    logic               acc_ovf;
    logic               fault;

    // The first digit of an operand starts from zero, later digits build on acc_q.
    assign acc_in = ((state_q == S_A) || (state_q == S_B)) ? acc_q : '0;

    // For '0'..'9' the low nibble is the digit value.
    dec_accum #(.WIDTH(WIDTH)) u_dec_accum (
        .acc      (acc_in),
        .digit    (i_data[3:0]),
        .acc_next (acc_sum),
        .overflow (acc_ovf)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        a_stage_d    = a_stage_q;
        op_d         = op_q;
        operand_a_d  = operand_a_q;
        operand_b_d  = operand_b_q;
        op_ready_d   = 1'b0;
        expr_valid_d = 1'b0;
        error_d      = 1'b0;
        fault        = 1'b0;

        if (i_valid && (i_data != CH_SPACE)) begin
            case (state_q)
                S_IDLE: begin
                    if (is_digit(i_data)) begin
                        acc_d   = acc_sum;
                        state_d = S_A;
                    end else if (!is_term(i_data)) begin
                        fault = 1'b1;
                    end
                end
                S_A: begin
                    if (is_digit(i_data)) begin
                        if (acc_ovf) fault = 1'b1;
                        else         acc_d = acc_sum;
                    end else if (is_op(i_data)) begin
                        a_stage_d  = acc_q;
                        op_d       = i_data;
                        op_ready_d = 1'b1;
                        acc_d      = '0;
                        state_d    = S_B0;
                    end else begin
                        fault = 1'b1;
                    end
                end
                S_B0: begin
                    if (is_digit(i_data)) begin
                        acc_d   = acc_sum;
                        state_d = S_B;
                    end else begin
                        fault = 1'b1;
                    end
                end
                S_B: begin
                    if (is_digit(i_data)) begin
                        if (acc_ovf) fault = 1'b1;
                        else         acc_d = acc_sum;
                    end else if (is_term(i_data)) begin
                        operand_a_d  = a_stage_q;
                        operand_b_d  = acc_q;
                        expr_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        fault = 1'b1;
                    end
                end
                S_ERR: begin
                    if (is_term(i_data)) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            // A faulting terminator already ends the line, so no resync is needed.
            if (fault) begin
                error_d = 1'b1;
                state_d = is_term(i_data) ? S_IDLE : S_ERR;
            end
        end
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            a_stage_q    <= '0;
            op_q         <= '0;
            operand_a_q  <= '0;
            operand_b_q  <= '0;
            op_ready_q   <= 1'b0;
            expr_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            a_stage_q    <= a_stage_d;
            op_q         <= op_d;
            operand_a_q  <= operand_a_d;
            operand_b_q  <= operand_b_d;
            op_ready_q   <= op_ready_d;
            expr_valid_q <= expr_valid_d;
            error_q      <= error_d;
        end
    end

    assign o_op_ready   = op_ready_q;
    assign o_op         = op_q;
    assign o_operand_a  = operand_a_q;
    assign o_operand_b  = operand_b_q;
    assign o_expr_valid = expr_valid_q;
    assign o_error      = error_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: doc/ascii_expr_parser.md
Name: ascii_expr_parser

Overview:
- Sits directly upstream of the operator-decode comparator and takes its byte stream from the UART receive stage.
- Parses ASCII infix expressions of the form `<A><op><B><term>`, e.g. "12+34=".
- Accumulates decimal operands, forwards the operator character with a one-cycle strobe into the comparator's `i_ready`/`op` inputs, and presents both binary operands to the arithmetic stage with a completion strobe.
- Malformed input raises an error strobe and the block resynchronises on the next terminator.

Parameters:
- WIDTH, 16, operand width in bits; the legal operand range is 0 .. 2^WIDTH-1.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  byte strobe from the UART receive stage, one cycle per byte.
- i_data  input  8  received ASCII byte; sampled only when `i_valid`=1.
- o_op_ready  output  1  one-cycle strobe; drives the comparator's `i_ready`.
- o_op  output  8  operator ASCII character; drives the comparator's `op`; holds until the next operator.
- o_operand_a  output  WIDTH  operand A; updated only on a successful expression.
- o_operand_b  output  WIDTH  operand B; updated only on a successful expression.
- o_expr_valid  output  1  one-cycle strobe: operands are valid for a complete expression.
- o_error  output  1  one-cycle strobe on the first syntax or overflow fault of an expression.
- o_busy  output  1  high while an expression is partially received (state not IDLE).

Behaviour:
- Reset (`reset_n`=0, asynchronous):
  - Every output is driven to 0 and the state goes to S_IDLE.
  - All accumulators and the staged operand A are cleared.
  - A reset mid-expression discards everything received so far.
- Character classes:
  - Digit: 0x30..0x39.
  - Operator: '+' 0x2B, '-' 0x2D, '*' 0x2A, '/' 0x2F.
  - Space: 0x20, ignored in every state except S_ERR, where it is also discarded.
  - Terminator: '=' 0x3D, CR 0x0D, LF 0x0D+... specifically LF 0x0A.
  - Any other byte is illegal.
- Bytes with `i_valid`=0 are ignored; there is no backpressure.
- Accumulation:
  - The accumulator is WIDTH bits wide; each digit computes acc_next = acc*10 + (i_data-0x30), evaluated at WIDTH+4 bits.
  - If acc_next exceeds 2^WIDTH-1, the byte is an overflow fault.
  - Leading zeros are legal.
- FSM states and transitions:
  - S_IDLE:
    - digit -> acc=d, go to S_A.
    - terminator -> stay in S_IDLE, silent (empty lines are tolerated).
    - operator or illegal byte -> fault.
  - S_A:
    - digit -> accumulate.
    - operator -> stage A=acc, o_op<=byte, o_op_ready=1 on the next cycle, clear acc, go to S_B0.
    - terminator or illegal byte -> fault.
  - S_B0:
    - digit -> acc=d, go to S_B.
    - anything else -> fault.
  - S_B:
    - digit -> accumulate.
    - terminator -> o_operand_a<=staged A, o_operand_b<=acc, o_expr_valid=1 on the next cycle, go to S_IDLE.
    - operator or illegal byte -> fault.
  - S_ERR:
    - discard bytes; a terminator returns the FSM to S_IDLE with no strobe.
- Fault handling:
  - o_error=1 for one cycle, the cycle after the faulting byte.
  - Next state is S_ERR, except that a terminator that is itself the faulting byte goes straight to S_IDLE.
  - Operands already on o_operand_a/o_operand_b remain unchanged.
- Latency:
  - Each strobe is registered and asserted exactly one cycle after the accepting `i_valid` edge, high for exactly one cycle.
  - At most one strobe fires per input byte.
- o_op_ready fires even if the expression later faults; the downstream block discards the operation when no o_expr_valid follows.
- Back-to-back `i_valid` on consecutive cycles is fully supported; every byte is processed.

Decomposition:
- Shared package expr_pkg holds:
  - ASCII constants: digits range, the four operators, space, '=', CR, LF.
  - The FSM state enum: S_IDLE, S_A, S_B0, S_B, S_ERR.
  - The operator character codes, also used by the comparator's parameter defaults.
- One natural sub-module, dec_accum: combinational acc*10+digit with an overflow flag, parameterised by WIDTH.

Test Plan:
- "12+34=" at 1 byte/cycle -> o_op_ready with o_op=0x2B one cycle after '+'; o_expr_valid with A=12, B=34 one cycle after '='; o_error never asserted.
- " 7 / 3\n" (spaces included) -> o_op=0x2F strobe; o_expr_valid with A=7, B=3.
- "65535*2\r" then "65536+1=" -> first expression gives A=65535, B=2. Second: o_error one cycle after the final '6'; no o_op_ready or o_expr_valid; operands stay 65535/2; o_busy returns low after '='.
- "+5=" then "9-1=" -> o_error after '+'; resync on '='; then o_op=0x2D strobe and o_expr_valid with A=9, B=1.
- "12+" then reset_n pulsed low asynchronously mid-cycle, then "4*25=" -> after reset all outputs are 0 and o_busy=0; then o_op=0x2A with A=4, B=25.
- "3+=" and "3+x4=" -> each gives exactly one o_error strobe and no o_expr_valid; the parser then accepts "1+1=" with A=1, B=1.
